gpio_irq_wb: RTL and testbench



---
 rtl/gpio_irq_pkg.sv | 36 +++
 rtl/gpio_debounce.sv | 45 ++++
 rtl/gpio_irq_wb.sv | 132 +++++++++++++
 tb/tb_gpio_irq_wb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO input-conditioning / interrupt stage:
// register offsets, register bit positions and the register-select decode.
package gpio_irq_pkg;

   localparam logic [7:0] OFF_CFG  = 8'h00;
   localparam logic [7:0] OFF_STAT = 8'h04;
   localparam logic [7:0] OFF_DEB  = 8'h08;

   localparam int unsigned CFG_IRQ_EN   = 0;
   localparam int unsigned CFG_RISE_EN  = 1;
   localparam int unsigned CFG_FALL_EN  = 2;

   localparam int unsigned STAT_PENDING = 0;
   localparam int unsigned STAT_STABLE  = 1;
   localparam int unsigned STAT_SYNC    = 2;

   localparam int unsigned DEB_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      RegCfg,
      RegStat,
      RegDeb,
      RegNone
   } reg_sel_e;

   function automatic reg_sel_e decode_offset(input logic [7:0] off,
                                              input logic [7:0] cfg_off,
                                              input logic [7:0] stat_off,
                                              input logic [7:0] deb_off);
      if (off == cfg_off)       return RegCfg;
      else if (off == stat_off) return RegStat;
      else if (off == deb_off)  return RegDeb;
      else                      return RegNone;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Debounce filter: stable follows s once they have differed for max(threshold,1) cycles.
// With GPIO_IRQ_DEBOUNCE_EN undefined it is a single pass-through flop.
module gpio_debounce #(
   parameter int unsigned DEB_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic [DEB_W-1:0] threshold,
   output logic             stable
);

`ifdef GPIO_IRQ_DEBOUNCE_EN
   logic [DEB_W-1:0] cnt;
   logic [DEB_W:0]   n;
   logic [DEB_W:0]   cnt_inc;

   // One extra bit so cnt+1 cannot wrap before the compare.
   assign n       = (threshold == '0) ? (DEB_W+1)'(1) : {1'b0, threshold};
   assign cnt_inc = {1'b0, cnt} + (DEB_W+1)'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (s == stable) begin
         cnt <= '0;
      end else if (cnt_inc >= n) begin
         stable <= s;
         cnt    <= '0;
      end else begin
         cnt <= cnt_inc[DEB_W-1:0];
      end
   end
`else
   logic unused_threshold;
   assign unused_threshold = ^threshold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stable <= 1'b0;
      else     stable <= s;
   end
`endif

endmodule

// File: rtl/gpio_irq_wb.sv
// Wishbone GPIO input stage: synchronizer, debounce, edge detect, sticky pending, irq.
// Define GPIO_IRQ_DEBOUNCE_EN to build the programmable debounce counter and DEB register.
module gpio_irq_wb
   import gpio_irq_pkg::*;
#(
   parameter logic [31:0]    BASE_ADR  = 32'h2100_0100,
   parameter logic [7:0]     IRQ_CFG   = OFF_CFG,
   parameter logic [7:0]     IRQ_STAT  = OFF_STAT,
   parameter logic [7:0]     IRQ_DEB   = OFF_DEB,
   parameter int unsigned    DEB_W     = DEB_W_DEFAULT,
   parameter logic [DEB_W-1:0] DEB_RESET = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_dat_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic        gpio_in_pad,
   output logic        irq_o
);

   logic       sync1, s;
   logic       stable, stable_d;
   logic       irq_en, rise_en, fall_en;
   logic       pending;
   logic       rise, fall, set_pending, clr_pending;
   logic       valid, wr;
   reg_sel_e   reg_sel;
   logic [31:0] rdata;
   logic [DEB_W-1:0] threshold;

   logic unused_bits;
   assign unused_bits = ^{wb_dat_i[31:3], wb_sel_i[3:1], DEB_RESET};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= gpio_in_pad;
         s     <= sync1;
      end
   end

   assign valid   = wb_cyc_i && wb_stb_i && !wb_ack_o && (wb_adr_i[31:8] == BASE_ADR[31:8]);
   assign wr      = valid && wb_we_i && wb_sel_i[0];
   assign reg_sel = decode_offset(wb_adr_i[7:0], IRQ_CFG, IRQ_STAT, IRQ_DEB);

`ifdef GPIO_IRQ_DEBOUNCE_EN
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)                    threshold <= DEB_RESET;
      else if (wr && reg_sel == RegDeb) threshold <= wb_dat_i[DEB_W-1:0];
   end
`else
   assign threshold = '0;
`endif

   gpio_debounce #(
      .DEB_W(DEB_W)
   ) u_debounce (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .s        (s),
      .threshold(threshold),
      .stable   (stable)
   );

   assign rise        = stable & ~stable_d;
   assign fall        = ~stable & stable_d;
   assign set_pending = (rise & rise_en) | (fall & fall_en);
   assign clr_pending = wr && (reg_sel == RegStat) && wb_dat_i[STAT_PENDING];

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         stable_d <= 1'b0;
         pending  <= 1'b0;
         irq_en   <= 1'b0;
         rise_en  <= 1'b0;
         fall_en  <= 1'b0;
      end else begin
         stable_d <= stable;
         // Set beats a coincident W1C so an edge is never lost.
         if (set_pending)      pending <= 1'b1;
         else if (clr_pending) pending <= 1'b0;
         if (wr && reg_sel == RegCfg) begin
            irq_en  <= wb_dat_i[CFG_IRQ_EN];
            rise_en <= wb_dat_i[CFG_RISE_EN];
            fall_en <= wb_dat_i[CFG_FALL_EN];
         end
      end
   end

   always_comb begin
      rdata = '0;
      unique case (reg_sel)
         RegCfg: begin
            rdata[CFG_IRQ_EN]  = irq_en;
            rdata[CFG_RISE_EN] = rise_en;
            rdata[CFG_FALL_EN] = fall_en;
         end
         RegStat: begin
            rdata[STAT_PENDING] = pending;
            rdata[STAT_STABLE]  = stable;
            rdata[STAT_SYNC]    = s;
         end
`ifdef GPIO_IRQ_DEBOUNCE_EN
         RegDeb:  rdata = 32'(threshold);
`else
         RegDeb:  rdata = '0;
`endif
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= valid;
         wb_dat_o <= valid ? rdata : '0;
      end
   end

   assign irq_o = pending & irq_en;

endmodule

// File: tb/tb_gpio_irq_wb.sv
// Directed bench for gpio_irq_wb; expectations follow GPIO_IRQ_DEBOUNCE_EN when defined.
module tb_gpio_irq_wb;

   localparam logic [31:0] BASE = 32'h2100_0100;
   localparam logic [31:0] A_CFG  = BASE + 32'h00;
   localparam logic [31:0] A_STAT = BASE + 32'h04;
   localparam logic [31:0] A_DEB  = BASE + 32'h08;
`ifdef GPIO_IRQ_DEBOUNCE_EN
   localparam int N = 4;
   localparam logic [31:0] DEB_RST_EXP = 32'h4;
   localparam logic [31:0] DEB_20_EXP  = 32'h20;
`else
   localparam int N = 1;
   localparam logic [31:0] DEB_RST_EXP = 32'h0;
   localparam logic [31:0] DEB_20_EXP  = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dat_i, adr, dat_o;
   logic [3:0]  sel;
   logic        cyc, stb, we, ack, pad, irq;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   gpio_irq_wb dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb_dat_i   (dat_i),
      .wb_adr_i   (adr),
      .wb_sel_i   (sel),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_dat_o   (dat_o),
      .wb_ack_o   (ack),
      .gpio_in_pad(pad),
      .irq_o      (irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called 1ns after a rising edge; returns 1ns after the ack edge (or after the bound).
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic acked);
      adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
      acked = 1'b0; rd = '0;
      for (int i = 0; i < 4 && !acked; i++) begin
         tick(1);
         if (ack) begin
            acked = 1'b1;
            rd    = dat_o;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr_reg(input string tag, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        acked;
      xfer(a, 1'b1, d, 4'b0001, rd, acked);
      chk(tag, 32'(acked), 32'h1);
   endtask

   task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      logic        acked;
      xfer(a, 1'b0, 32'h0, 4'b1111, rd, acked);
      if (!acked) chk({tag, "_ack"}, 32'(acked), 32'h1);
      else        chk(tag, rd, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic        acked;
      int          first;
      int          acks;

      rst = 1'b1; dat_i = '0; adr = '0; sel = '0; cyc = 0; stb = 0; we = 0; pad = 0;
      tick(3);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      rst = 1'b0;
      tick(1);
      rd_reg("rst_cfg", A_CFG, 32'h0);
      rd_reg("rst_deb", A_DEB, DEB_RST_EXP);
      rd_reg("rst_stat", A_STAT, 32'h0);

      // Debounced rise: irq exactly N+2 edges after the first sampling edge.
      wr_reg("w_deb", A_DEB, 32'h4);
      wr_reg("w_cfg3", A_CFG, 32'h3);
      pad = 1'b1;
      first = -1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (irq && first < 0) first = i;
      end
      chk("rise_irq_edge", 32'(first), 32'(N + 2));
      rd_reg("rise_stat", A_STAT, 32'h7);

      pad = 1'b0;
      tick(10);
      wr_reg("w_clr", A_STAT, 32'h1);
      rd_reg("clr_stat", A_STAT, 32'h0);
      chk("clr_irq", 32'(irq), 32'h0);

`ifdef GPIO_IRQ_DEBOUNCE_EN
      // Three-cycle pulse is shorter than N=4.
      pad = 1'b1;
      tick(3);
      pad = 1'b0;
      tick(10);
      rd_reg("glitch_stat", A_STAT, 32'h0);
`endif

      // W1C landing on the same edge as a falling-edge set.
      wr_reg("w_cfg5", A_CFG, 32'h5);
      pad = 1'b1;
      tick(10);
      rd_reg("race_pre_stat", A_STAT, 32'h6);
      pad = 1'b0;
      tick(N + 2);
      chk("race_pre_irq", 32'(irq), 32'h0);
      wr_reg("w_race_clr", A_STAT, 32'h1);
      chk("race_irq", 32'(irq), 32'h1);
      rd_reg("race_stat", A_STAT, 32'h1);
      wr_reg("w_clr2", A_STAT, 32'h1);
      rd_reg("clr2_stat", A_STAT, 32'h0);

      // Bus decode corner cases.
      xfer(A_CFG, 1'b1, 32'h0, 4'b0010, rd, acked);
      chk("sel1_ack", 32'(acked), 32'h1);
      rd_reg("sel1_cfg", A_CFG, 32'h5);
      xfer(BASE + 32'h10, 1'b0, 32'h0, 4'b1111, rd, acked);
      chk("undef_ack", 32'(acked), 32'h1);
      chk("undef_dat", rd, 32'h0);
      xfer(32'h2100_0210, 1'b0, 32'h0, 4'b1111, rd, acked);
      chk("outside_ack", 32'(acked), 32'h0);

      adr = A_CFG; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (ack) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("b2b_acks", 32'(acks), 32'h2);
      tick(1);

      wr_reg("w_deb20", A_DEB, 32'h20);
      rd_reg("deb20", A_DEB, DEB_20_EXP);
      wr_reg("w_deb4", A_DEB, 32'h4);

      // Async reset in the middle of an acked transfer with irq asserted.
      wr_reg("w_cfg7", A_CFG, 32'h7);
      pad = 1'b1;
      tick(N + 6);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      adr = A_CFG; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      tick(1);
      chk("pre_rst_ack", 32'(ack), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ack", 32'(ack), 32'h0);
      chk("mid_rst_irq", 32'(irq), 32'h0);
      cyc = 1'b0; stb = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      rd_reg("post_rst_cfg", A_CFG, 32'h0);
      rd_reg("post_rst_deb", A_DEB, DEB_RST_EXP);
      tick(N + 10);
      rd_reg("post_rst_stat", A_STAT, 32'h6);
      chk("post_rst_irq", 32'(irq), 32'h0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
